// File: rtl/mdu_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int unsigned STEP_COUNT = 32;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } state_e;

    // Two's-complement negate when neg is set.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Operands are reduced to magnitudes at issue, 32 radix-2 steps run in CALC,
// and signs are reapplied in FIX, where HI/LO are committed.
module ex_muldiv
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] srcl,
    input  logic [31:0] rtdata,
    input  logic        flush,
    input  logic        hilo_use,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q;
    logic [63:0] acc_q;          // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [31:0] b_q;            // multiplicand / divisor magnitude
    logic [31:0] dvd_q;          // raw dividend, returned as HI on divide by zero
    logic        is_div_q, neg_res_q, neg_rem_q, div_zero_q;
    logic [31:0] hi_q, lo_q;
    logic        mt_done_q;

    logic        issue_ok, is_mdu, is_mt, signed_op, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum, rem_shift, div_diff;
    logic        q_bit;
    logic [63:0] mul_next, div_next, prod_fix;
    logic [31:0] fix_hi, fix_lo;

    assign issue_ok  = (state_q == StIdle) && start && !flush;
    assign is_mdu    = (op[2] == 1'b0);
    assign is_mt     = (op == OP_MTHI) || (op == OP_MTLO);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg     = signed_op && srcl[31];
    assign b_neg     = signed_op && rtdata[31];
    assign a_mag     = neg_if(srcl, a_neg);
    assign b_mag     = neg_if(rtdata, b_neg);

    // One radix-2 step of shift-add multiply and restoring divide, plus sign fixup.
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};
        rem_shift = {acc_q[63:32], acc_q[31]};
        // Remainder stays below the divisor, so bit 32 of the difference is the borrow.
        div_diff  = rem_shift - {1'b0, b_q};
        q_bit     = ~div_diff[32];
        div_next  = {(q_bit ? div_diff[31:0] : rem_shift[31:0]), acc_q[30:0], q_bit};
        prod_fix  = neg_res_q ? (64'd0 - acc_q) : acc_q;
        fix_hi    = prod_fix[63:32];
        fix_lo    = prod_fix[31:0];
        if (is_div_q) begin
            if (div_zero_q) begin
                fix_hi = dvd_q;
                fix_lo = 32'hFFFF_FFFF;
            end else begin
                fix_hi = neg_if(acc_q[63:32], neg_rem_q);
                fix_lo = neg_if(acc_q[31:0], neg_res_q);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush always returns to idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (issue_ok && is_mdu) state_d = StCalc;
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (cnt_q == 6'(STEP_COUNT - 1)) begin
                    state_d = StFix;
                end
            end
            StFix:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Status outputs; a flushed FIX cycle neither commits nor reports done.
    always_comb begin
        busy  = (state_q != StIdle);
        done  = ((state_q == StFix) && !flush) || mt_done_q;
        stall = hilo_use && busy;
    end

    // Datapath, counter and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            dvd_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            mt_done_q  <= 1'b0;
        end else begin
            mt_done_q <= issue_ok && is_mt;
            unique case (state_q)
                StIdle: begin
                    if (issue_ok && is_mdu) begin
                        acc_q      <= {32'd0, a_mag};
                        b_q        <= b_mag;
                        dvd_q      <= srcl;
                        cnt_q      <= '0;
                        is_div_q   <= op[1];
                        neg_res_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        div_zero_q <= (rtdata == 32'd0);
                    end
                    if (issue_ok && (op == OP_MTHI)) hi_q <= srcl;
                    if (issue_ok && (op == OP_MTLO)) lo_q <= srcl;
                end
                StCalc: begin
                    acc_q <= is_div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + 6'd1;
                end
                StFix: begin
                    if (!flush) begin
                        hi_q <= fix_hi;
                        lo_q <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage, consuming the operand and control bundle registered by the ID/EX pipeline register. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation per issue, computes over multiple cycles, and holds the architectural HI/LO registers. It raises a stall request toward the hazard logic while a later instruction needs HI/LO before the result is ready.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  issue strobe from ID/EX; one-cycle pulse per instruction
- op  in  3  operation code (mdu_pkg encodings)
- srcl  in  32  rs operand (ID/EX srcl_out)
- rtdata  in  32  rt operand (ID/EX RTdata_out)
- flush  in  1  abort in-flight operation (branch/exception squash)
- hilo_use  in  1  instruction in ID reads HI/LO or issues an MDU op
- busy  out  1  computation in progress
- done  out  1  one-cycle pulse when HI/LO update is committed
- stall  out  1  combinational: hilo_use & busy
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start with MULT/MULTU/DIV/DIVU: latch operand magnitudes (signed ops take absolute value; unsigned pass through), record result signs, clear 6-bit counter, go CALC.
- IDLE, start with MTHI/MTLO: write srcl to hi/lo at that edge, stay IDLE, pulse done next cycle; busy stays 0.
- CALC: one radix-2 step per cycle (multiply: shift-add into 64-bit product; divide: restoring shift-subtract, quotient bits into lo side, remainder in hi side). Counter 0..31; at 31 go FIX.
- FIX: apply signs (product negated if operand signs differ; quotient negated if signs differ; remainder takes dividend sign); write hi/lo at end of FIX; done=1 during FIX; go IDLE.
- Divide by zero: no trap; lo = 32'hFFFF_FFFF, hi = dividend (srcl) unchanged in sign; still takes full latency.
- Signed DIV of 32'h8000_0000 by 32'hFFFF_FFFF: lo = 32'h8000_0000, hi = 0.
- start while busy: ignored (hazard logic must prevent it); bench flags it as protocol error.
- flush: in CALC/FIX returns to IDLE next cycle, hi/lo unchanged, no done. Flush with start in IDLE: flush wins, nothing issued.
- Reset: state IDLE, hi=0, lo=0, busy=0, done=0, counter=0; applies mid-operation with no partial write.

## Timing
- Start sampled at edge N; busy=1 in cycles N+1..N+33 (32 CALC + 1 FIX); done=1 in cycle N+33; new hi/lo visible from cycle N+34.
- Back-to-back: next start accepted in cycle N+34 (state IDLE).
- MTHI/MTLO: value visible cycle after the issuing edge.
- stall has no register delay; deasserts in cycle N+34.
- hi/lo only change at FIX exit, MTHI/MTLO, or reset.

## Structure
- mdu_pkg: op encodings (OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5), state enum, STEP_COUNT=32.
- Single module; datapath (64-bit accumulator, 33-bit subtractor) inline; no sub-module.

## Test plan
- MULT srcl=-3 (32'hFFFF_FFFD), rtdata=7 -> done at N+33; hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
- DIVU srcl=100, rtdata=7 -> lo=14, hi=2; DIV srcl=-100, rtdata=7 -> lo=-14, hi=-2.
- DIV by zero srcl=5 -> lo=32'hFFFF_FFFF, hi=5; DIV 32'h8000_0000 / -1 -> lo=32'h8000_0000, hi=0.
- hilo_use=1 during busy -> stall=1 exactly cycles N+1..N+33, 0 at N+34.
- flush at cycle N+10 of MULTU 2*3 -> busy drops at N+11, no done, hi/lo retain prior values; same for rst_n=0 mid-CALC -> hi=lo=0.
- MTHI 32'hDEAD_BEEF then MTLO 32'h1234_5678 consecutive cycles -> hi/lo read back, busy never asserted.
